// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared prescaled period counter, double-buffered duty per channel.
// Define PWM_CENTER_ALIGNED_EN for a triangle (up/down) counter.
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  en_out,
  input  logic [NUM_CH-1:0]  en_pwm,
  input  logic [CNT_W-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               duty_we,
  input  logic [SEL_W-1:0]   duty_sel,
  input  logic [CNT_W-1:0]   duty_wdata,
  output logic [NUM_CH-1:0]  out,
  output logic               frame_start,
  output logic [CNT_W-1:0]   cnt_value
);

  localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(NUM_CH);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   shadow_q [NUM_CH];
  logic [CNT_W-1:0]   active_q [NUM_CH];
  logic [NUM_CH-1:0]  out_q, out_d;
  logic               fs_q;
  logic               tick;
  logic               wrap;
  logic               sel_ok;

  // >= keeps the prescaler bounded if prescale drops below the count
  assign tick    = presc_q >= prescale;
  assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  assign sel_ok  = {1'b0, duty_sel} < NCH_L;

`ifdef PWM_CENTER_ALIGNED_EN
  logic dir_q, dir_d;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (tick) begin
      if (period == '0) begin
        cnt_d = '0;
        dir_d = 1'b0;
        wrap  = 1'b1;
      end else if (!dir_q) begin
        if (cnt_q >= period) begin
          cnt_d = cnt_q - CNT_W'(1);
          dir_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (cnt_q <= CNT_W'(1)) begin
        cnt_d = '0;
        dir_d = 1'b0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end
`else
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (tick) begin
      if (cnt_q >= period) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end
`endif

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_d[i] = en_out[i] & (~en_pwm[i] | (cnt_q < active_q[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      fs_q    <= wrap;
    end
  end

  // Shadow is read before the write lands, so a wrap-cycle write waits a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wrap) begin
        for (int i = 0; i < NUM_CH; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
      if (duty_we && sel_ok) begin
        shadow_q[duty_sel] <= duty_wdata;
      end
    end
  end

  assign out         = out_q;
  assign frame_start = fs_q;
  assign cnt_value   = cnt_q;

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Parametrised successor to the fixed 16-output PWM peripheral. Drives NUM_CH outputs from one shared, prescaled period counter. Each channel has its own double-buffered duty register and its own output-enable and PWM-enable bits. Sits between the SPI register file and the chip output pins ({uio_out, uo_out} for NUM_CH=16).

Parameters:
NUM_CH, 16, number of output channels (1..32)
CNT_W, 8, width of period counter, period and duty values
PRESC_W, 8, width of prescaler counter and prescale value
SEL_W, 4, width of duty channel select; must satisfy 2**SEL_W >= NUM_CH

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_out  input  NUM_CH  per-channel output enable; 0 forces the output low
en_pwm  input  NUM_CH  per-channel mode; 1 = PWM, 0 = static high when enabled
period  input  CNT_W  counter terminal value; frame length is period+1 ticks
prescale  input  PRESC_W  tick divider; one tick every prescale+1 clk cycles
duty_we  input  1  write strobe for a duty shadow register
duty_sel  input  SEL_W  channel index for duty_we
duty_wdata  input  CNT_W  duty value to write
out  output  NUM_CH  registered PWM outputs
frame_start  output  1  one-cycle pulse when the counter wraps to 0
cnt_value  output  CNT_W  current period counter value (debug/readback)

Behaviour:
- Reset (async, rst_n=0): out=0, frame_start=0, cnt_value=0, prescaler=0, all duty shadow and active registers = 0.
- Prescaler:
  - Counts 0..prescale.
  - tick=1 in the cycle where presc==prescale; presc then returns to 0.
  - prescale=0 gives tick every cycle.
- Period counter advances only on tick:
  - If cnt >= period, cnt <= 0 (wrap). Otherwise cnt <= cnt+1.
  - The >= comparison covers a period reduced mid-frame below the current cnt: wrap on the next tick, with no run to overflow.
  - period=0: cnt stays 0 and wraps on every tick.
- Frame boundary:
  - frame_start is a registered pulse, high for exactly one clk cycle after each wrap.
  - In that same wrap cycle, every duty_active[i] <= duty_shadow[i].
- Duty writes:
  - duty_we=1 writes duty_shadow[duty_sel] <= duty_wdata.
  - duty_sel >= NUM_CH is ignored; no state changes.
  - A write in the same cycle as a wrap commits the previously held shadow value. The new value takes effect at the next wrap.
  - Only the frame boundary moves shadow to active; a value never takes effect mid-frame.
- Output, registered with 1 clk latency from cnt:
  - out[i] <= en_out[i] & (en_pwm[i] ? (cnt < duty_active[i]) : 1).
  - duty=0: constant low.
  - duty > period: constant high.
  - duty=period: low only during cnt==period.
- en_out and en_pwm are level inputs sampled every cycle. They take effect on the next clk edge with no frame alignment.
- Reset mid-frame: everything returns to reset values immediately. Duty values written before reset are lost.

Optional Feature:
Macro: PWM_CENTER_ALIGNED_EN.
- Defined:
  - Counter counts up 0..period, then down period..0 (triangle). At cnt==period the direction flips to down; at cnt==0 it flips to up.
  - Wrap and frame_start occur when the down-count reaches 0, giving 2*period ticks per frame; period=0 holds cnt at 0 and pulses every tick.
  - Output rule is unchanged (cnt < duty), so each high pulse is centred on cnt==0.
  - Shadow-to-active copy happens at that 0 point.
- Not defined: edge-aligned up-counter only. No direction register is synthesised.

Test Plan:
1. Reset release; prescale=0, period=9, en_out=en_pwm=all 1s, write duty ch0=3 -> out[0] low for frame 1 (active duty 0). From frame 2, out[0] high 3 cycles, low 7; frame_start every 10 cycles.
2. prescale=3, period=4, ch1 duty=2 -> cnt advances every 4 clk; out[1] high 8 clk, low 12 clk per 20-clk frame.
3. Mid-frame (cnt=5) write ch2 duty 8 over previous 2, period=9 -> out[2] keeps 2-tick pulse until next frame_start, then 8-tick pulse. Duty_we in the wrap cycle itself is deferred one frame.
4. Boundaries with period=9: duty=0 -> out constant 0; duty=10 and duty=255 -> constant 1; en_pwm=0, en_out=1 -> constant 1; en_out=0 -> 0 regardless of duty.
5. Counter at cnt=7, period changed 9->4 -> cnt wraps to 0 on next tick and frame_start pulses. Write with duty_sel=NUM_CH -> no register changes.
6. PWM_CENTER_ALIGNED_EN, period=4, duty=2 -> cnt sequence 0,1,2,3,4,3,2,1,0,1,...; out high at cnt 0,1 on both slopes; frame_start every 8 ticks. Assert rst_n mid-frame -> out=0 and cnt=0 immediately.
